ins_prefetch: RTL and testbench

INS_PREFETCH -- requirements
Module: ins_prefetch

---
 rtl/ins_prefetch_pkg.sv | 24 ++
 rtl/ins_fifo2.sv | 71 +++++++
 rtl/ins_prefetch.sv | 146 ++++++++++++++
 tb/tb_ins_prefetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_prefetch_pkg.sv
// ins_prefetch_pkg
// Purpose: declarations shared by the instruction prefetch unit and its
//   two-entry buffer: the data word width, the buffer depth, the fetch FSM
//   state encoding and the {pc, word} buffer entry type.
// Ports: none (package).
package ins_prefetch_pkg;

  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 2;

  // IDLE: no read outstanding. WAIT: read outstanding, data will be kept.
  // DROP: read outstanding, data will be thrown away (flushed by jump/excp).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/ins_fifo2.sv
// ins_fifo2
// Purpose: two-entry {pc, word} buffer with synchronous flush and
//   simultaneous push/pop. Empty slots read as zero.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_flush          discard all entries (dominates push/pop)
//   i_push           write i_push_entry (caller guarantees room after pop)
//   i_push_entry     {pc, word} to write
//   i_pop            remove head entry (ignored when empty)
//   o_count          number of valid entries (0..2)
//   o_head           head entry, zero when empty
//   o_next_word      word of second entry, zero when fewer than two entries
module ins_fifo2
  import ins_prefetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  fifo_entry_t       i_push_entry,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output fifo_entry_t       o_head,
  output logic [WORD_W-1:0] o_next_word
);

  fifo_entry_t r_head;
  fifo_entry_t r_second;
  logic [1:0]  r_count;
  logic        w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  // Entries shift toward the head on a pop; a push lands in the first slot
  // that is free once this cycle's pop has been accounted for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_second <= '0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b01: begin
          r_head  <= r_second;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_head   <= i_push_entry;
          else                 r_second <= i_push_entry;
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_push_entry;
          end else begin
            r_head   <= r_second;
            r_second <= i_push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_head      = (r_count != 2'd0) ? r_head : '0;
  assign o_next_word = (r_count == 2'd2) ? r_second.word : '0;

endmodule

// File: rtl/ins_prefetch.sv
// ins_prefetch
// Purpose: instruction prefetcher. Keeps a two-entry buffer of fetched
//   instructions filled from a single-outstanding-request memory port,
//   handles jump redirects and exception entry (with saved return PC).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   o_mem_req, o_mem_addr      memory read request / address
//   i_mem_ack, i_mem_data      read data valid / instruction word
//   i_take                     consumer pops the head instruction
//   o_ins_valid, o_ins, o_ins_pc, o_ins_next   buffered instruction view
//   i_jump, i_jump_addr        redirect fetch
//   i_excp                     exception entry (wins over jump)
//   o_save_excp, o_saved_pc    one-cycle entry pulse / captured return PC
module ins_prefetch
  import ins_prefetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] EXCP_VEC = 16'h0010
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_mem_req,
  output logic [WORD_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [WORD_W-1:0] i_mem_data,
  input  logic              i_take,
  output logic              o_ins_valid,
  output logic [WORD_W-1:0] o_ins,
  output logic [WORD_W-1:0] o_ins_next,
  output logic [WORD_W-1:0] o_ins_pc,
  input  logic              i_jump,
  input  logic [WORD_W-1:0] i_jump_addr,
  input  logic              i_excp,
  output logic              o_save_excp,
  output logic [WORD_W-1:0] o_saved_pc
);

  localparam logic [1:0] DEPTH_CNT = 2'(FIFO_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] w_fetch_pc_next;
  logic [WORD_W-1:0] r_mem_addr;
  logic              r_save_excp;
  logic [WORD_W-1:0] r_saved_pc;
  logic              w_issue;
  logic              w_flush;
  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_count;
  logic [1:0]        w_occ_after_take;
  fifo_entry_t       w_head;
  fifo_entry_t       w_push_entry;
  logic [WORD_W-1:0] w_next_word;

  // A flush (jump or exception) swallows a same-cycle take and any ack.
  assign w_flush          = i_excp | i_jump;
  assign w_pop            = i_take && (w_count != 2'd0) && !w_flush;
  assign w_push           = (r_state == ST_WAIT) && i_mem_ack && !w_flush;
  assign w_occ_after_take = w_count - {1'b0, w_pop};
  assign w_push_entry     = '{pc: r_fetch_pc, word: i_mem_data};

  ins_fifo2 u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_flush),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head       (w_head),
    .o_next_word  (w_next_word)
  );

  // In WAIT, r_fetch_pc is the address of the outstanding read. Whenever a
  // request is issued its address equals the next fetch_pc, so one value
  // feeds both the fetch pointer and the memory address register.
  always_comb begin
    w_next_state    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_issue         = 1'b0;
    if (w_flush) begin
      w_fetch_pc_next = i_excp ? EXCP_VEC : i_jump_addr;
      w_next_state    = ((r_state != ST_IDLE) && !i_mem_ack) ? ST_DROP : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_occ_after_take < DEPTH_CNT) begin
            w_issue      = 1'b1;
            w_next_state = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            w_fetch_pc_next = r_fetch_pc + 16'd1;
            if ((w_occ_after_take + 2'd1) < DEPTH_CNT) begin
              w_issue      = 1'b1;
              w_next_state = ST_WAIT;
            end else begin
              w_next_state = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (i_mem_ack) w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_fetch_pc_next;
      if (w_issue) r_mem_addr <= w_fetch_pc_next;
    end
  end

  // Return address is the oldest unexecuted instruction if one is buffered,
  // otherwise the address the prefetcher would fetch next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_save_excp <= 1'b0;
      r_saved_pc  <= '0;
    end else begin
      r_save_excp <= i_excp;
      if (i_excp) r_saved_pc <= (w_count != 2'd0) ? w_head.pc : r_fetch_pc;
    end
  end

  assign o_mem_req   = (r_state != ST_IDLE);
  assign o_mem_addr  = r_mem_addr;
  assign o_ins_valid = (w_count != 2'd0);
  assign o_ins       = w_head.word;
  assign o_ins_pc    = w_head.pc;
  assign o_ins_next  = w_next_word;
  assign o_save_excp = r_save_excp;
  assign o_saved_pc  = r_saved_pc;

endmodule

// File: tb/tb_ins_prefetch.sv
// tb_ins_prefetch
// Purpose: directed bench for ins_prefetch. A memory process answers reads
//   (automatically with 16'hA000+addr, or with hand-driven ack/data), the
//   stimulus thread pushes the expected {pc, word} of each consumed
//   instruction into a queue, and a monitor pops and compares whenever an
//   instruction is actually taken.
module tb_ins_prefetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        take;
  logic        ins_valid;
  logic [15:0] ins;
  logic [15:0] ins_next;
  logic [15:0] ins_pc;
  logic        jump;
  logic [15:0] jump_addr;
  logic        excp;
  logic        save_excp;
  logic [15:0] saved_pc;

  int          vectorsApplied = 0;
  int          miscompares    = 0;
  logic [31:0] sbQueue[$];
  bit          memAuto;
  logic        manualAck;
  logic [15:0] manualData;

  ins_prefetch #(.RESET_PC(16'h0000), .EXCP_VEC(16'h0010)) dut (
    .clk         (clk),
    .rst         (rst),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_ack   (mem_ack),
    .i_mem_data  (mem_data),
    .i_take      (take),
    .o_ins_valid (ins_valid),
    .o_ins       (ins),
    .o_ins_next  (ins_next),
    .o_ins_pc    (ins_pc),
    .i_jump      (jump),
    .i_jump_addr (jump_addr),
    .i_excp      (excp),
    .o_save_excp (save_excp),
    .o_saved_pc  (saved_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic j,
                               input logic [15:0] ja, input logic e);
    take      = t;
    jump      = j;
    jump_addr = ja;
    excp      = e;
  endtask

  // Memory model: answers just after the falling edge so ack/data are
  // stable at the next rising edge.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (memAuto) begin
        mem_ack  = mem_req;
        mem_data = 16'hA000 + mem_addr;
      end else begin
        mem_ack  = manualAck;
        mem_data = manualData;
      end
    end
  end

  // Monitor: an instruction is consumed when it is valid and taken with no
  // flush in the same cycle.
  initial begin
    logic [31:0] expEntry;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && ins_valid && take && !jump && !excp) begin
        if (sbQueue.size() == 0) begin
          vectorsApplied++;
          miscompares++;
          $display("[TB] FAIL unexpected_take: got pc %h ins %h, expected none", ins_pc, ins);
        end else begin
          expEntry = sbQueue.pop_front();
          checkOutput("take_pc", ins_pc, expEntry[31:16]);
          checkOutput("take_ins", ins, expEntry[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    rst        = 1'b1;
    memAuto    = 1'b1;
    manualAck  = 1'b0;
    manualData = 16'h0000;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_mem_req",   16'(mem_req),   16'd0);
    checkOutput("rst_mem_addr",  mem_addr,       16'h0000);
    checkOutput("rst_ins_valid", 16'(ins_valid), 16'd0);
    checkOutput("rst_ins",       ins,            16'h0000);
    checkOutput("rst_ins_next",  ins_next,       16'h0000);
    checkOutput("rst_ins_pc",    ins_pc,         16'h0000);
    checkOutput("rst_save_excp", 16'(save_excp), 16'd0);
    checkOutput("rst_saved_pc",  saved_pc,       16'h0000);
    rst = 1'b0;

    // Fill after reset release
    @(negedge clk);
    checkOutput("first_req",      16'(mem_req), 16'd1);
    checkOutput("first_req_addr", mem_addr,     16'h0000);
    @(negedge clk);
    checkOutput("second_req_addr", mem_addr,       16'h0001);
    checkOutput("fill_valid",      16'(ins_valid), 16'd1);
    checkOutput("fill_ins",        ins,            16'hA000);
    @(negedge clk);
    checkOutput("fill_ins_next", ins_next,     16'hA001);
    checkOutput("full_no_req",   16'(mem_req), 16'd0);
    @(negedge clk);
    checkOutput("full_still_no_req", 16'(mem_req), 16'd0);
    checkOutput("full_ins_pc",       ins_pc,       16'h0000);

    // Streaming: take held, one instruction per cycle
    for (int i = 0; i < 12; i++) sbQueue.push_back({16'(i), 16'hA000 + 16'(i)});
    take = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("stream_no_bubble", 16'(ins_valid), 16'd1);
    end
    take = 1'b0;
    checkOutput("stream_drained", 16'(sbQueue.size()), 16'd0);

    // Jump while WAIT, stale data discarded
    @(negedge clk);
    memAuto = 1'b0;
    sbQueue.push_back({16'h000C, 16'hA00C});
    take = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("drop_req_held",  16'(mem_req),   16'd1);
    checkOutput("drop_addr_held", mem_addr,       16'h000E);
    checkOutput("jump_flushed",   16'(ins_valid), 16'd0);
    @(negedge clk);
    manualAck  = 1'b1;
    manualData = 16'hDEAD;
    @(negedge clk);
    manualAck = 1'b0;
    checkOutput("dead_discarded", 16'(ins_valid), 16'd0);
    checkOutput("drop_to_idle",   16'(mem_req),   16'd0);
    @(negedge clk);
    checkOutput("jump_req",      16'(mem_req),   16'd1);
    checkOutput("jump_req_addr", mem_addr,       16'h0200);
    checkOutput("jump_empty",    16'(ins_valid), 16'd0);
    manualAck  = 1'b1;
    manualData = 16'h1234;
    @(negedge clk);
    manualAck = 1'b0;
    checkOutput("jump_ins",      ins,            16'h1234);
    checkOutput("jump_ins_pc",   ins_pc,         16'h0200);
    checkOutput("jump_valid",    16'(ins_valid), 16'd1);
    checkOutput("one_entry_next", ins_next,      16'h0000);

    // Exception with jump and take in the same cycle
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    memAuto = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("pre_excp_pc",   ins_pc,   16'h0005);
    checkOutput("pre_excp_next", ins_next, 16'hA006);
    applyStimulus(1'b1, 1'b1, 16'h0300, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("save_excp_pulse", 16'(save_excp), 16'd1);
    checkOutput("saved_pc",        saved_pc,       16'h0005);
    checkOutput("excp_flushed",    16'(ins_valid), 16'd0);
    @(negedge clk);
    checkOutput("save_excp_one_cycle", 16'(save_excp), 16'd0);
    checkOutput("excp_req",            16'(mem_req),   16'd1);
    checkOutput("excp_vec_addr",       mem_addr,       16'h0010);

    // Address wrap at 16'hFFFF (also same-cycle ack discarded by jump)
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("flush_same_ack", 16'(ins_valid), 16'd0);
    @(negedge clk);
    checkOutput("ffff_addr", mem_addr, 16'hFFFF);
    @(negedge clk);
    checkOutput("wrap_addr",   mem_addr, 16'h0000);
    checkOutput("ffff_ins_pc", ins_pc,   16'hFFFF);
    checkOutput("ffff_ins",    ins,      16'h9FFF);
    @(negedge clk);
    memAuto = 1'b0;
    sbQueue.push_back({16'hFFFF, 16'h9FFF});
    sbQueue.push_back({16'h0000, 16'hA000});
    take = 1'b1;
    repeat (2) @(negedge clk);
    take = 1'b0;
    checkOutput("empty_valid",    16'(ins_valid), 16'd0);
    checkOutput("empty_ins",      ins,            16'h0000);
    checkOutput("empty_ins_next", ins_next,       16'h0000);
    checkOutput("wait_addr_1",    mem_addr,       16'h0001);
    checkOutput("wrap_drained",   16'(sbQueue.size()), 16'd0);

    // Reset during WAIT, late ack after release
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_req",  16'(mem_req), 16'd0);
    checkOutput("async_rst_addr", mem_addr,     16'h0000);
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    manualAck  = 1'b1;
    manualData = 16'hBEEF;
    @(negedge clk);
    manualAck = 1'b0;
    checkOutput("post_rst_req",      16'(mem_req),   16'd1);
    checkOutput("post_rst_addr",     mem_addr,       16'h0000);
    checkOutput("post_rst_valid",    16'(ins_valid), 16'd0);
    @(negedge clk);
    checkOutput("late_ack_ignored",  16'(ins_valid), 16'd0);
    checkOutput("post_rst_ins",      ins,            16'h0000);
    checkOutput("post_rst_saved_pc", saved_pc,       16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
